mem_arbiter: RTL and testbench

- Shares the single-port 16-bit `memory` block (RAM banks, ROM, VRAM) between up to NUM_REQ requesters, e.g. CPU, video scanout and DMA.
- Round-robin arbitration with optional per-requester burst lock.
- Drives the memory address, write-data and write-enable lines.
- Routes the one-cycle-latency read data back to the requester that issued the read.

---
 rtl/mem_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port memory (16-bit, registered read data) between
// NUM_REQ requesters using round-robin arbitration with an optional
// per-requester burst lock.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req/lock/we       per-port request, burst-lock and write flags
//   addr/wdata        per-port address/write data, port i at [i*W +: W]
//   gnt               one-hot grant; the access is taken at the next posedge
//   rvalid            per-port read-data-valid, one cycle after a read grant
//   rdata             shared read data (passthrough of mem_rdata)
//   mem_addr/mem_wdata/mem_we   memory drive, follows the granted port
//   mem_rdata         memory read data
//
// Optional feature, macro MEM_ARB_STATS_EN:
//   stat_clr          synchronous clear of the grant counters
//   stat_grants       per-port saturating 16-bit accepted-access counters
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic                      mem_we,
    input  logic [DATA_W-1:0]         mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    input  logic                      stat_clr,
    output logic [NUM_REQ*16-1:0]     stat_grants
`endif
);

    localparam int               IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W-1:0] ONE_IDX     = IDX_W'(1);
    localparam logic [IDX_W-1:0] ZERO_IDX    = IDX_W'(0);
    localparam logic [7:0]       MAX_BURST_W = 8'(MAX_BURST);
    // A burst of one is just a normal access, so lock has no effect then.
    localparam bit               BURST_EN    = (MAX_BURST > 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t               state_r;
    logic [IDX_W-1:0]     rr_ptr_r;
    logic [IDX_W-1:0]     owner_r;
    logic [7:0]           burst_cnt_r;
    logic [NUM_REQ-1:0]   rvalid_r;

    logic                 win_vld_s;
    logic [IDX_W-1:0]     win_idx_s;
    logic [IDX_W-1:0]     scan_idx_s;
    logic                 acc_s;
    logic [NUM_REQ-1:0]   gnt_s;
    logic [7:0]           burst_nxt_s;

    // Next port index in rotation, wrapping NUM_REQ-1 back to 0.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] nxt;
        if (idx == LAST_IDX) begin
            nxt = ZERO_IDX;
        end else begin
            nxt = idx + ONE_IDX;
        end
        return nxt;
    endfunction

    // Pick the winning port: rotating scan when idle, owner only when locked.
    always_comb begin
        win_vld_s  = 1'b0;
        win_idx_s  = ZERO_IDX;
        scan_idx_s = rr_ptr_r;
        case (state_r)
            ST_IDLE: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    // First requesting port from rr_ptr onwards wins.
                    win_idx_s  = (!win_vld_s && req[scan_idx_s]) ? scan_idx_s : win_idx_s;
                    win_vld_s  = win_vld_s | req[scan_idx_s];
                    scan_idx_s = wrap_inc(scan_idx_s);
                end
            end
            ST_LOCKED: begin
                win_vld_s = req[owner_r];
                win_idx_s = owner_r;
            end
            default: begin
                win_vld_s = 1'b0;
                win_idx_s = ZERO_IDX;
            end
        endcase
    end

    // Grant is suppressed while reset is asserted so all outputs read zero.
    assign acc_s       = win_vld_s & rst_n;
    assign burst_nxt_s = burst_cnt_r + 8'd1;

    // One-hot grant vector from the winning index.
    always_comb begin
        gnt_s            = {NUM_REQ{1'b0}};
        gnt_s[win_idx_s] = acc_s;
    end

    // Steer the granted port onto the memory; park at zero with no grant.
    always_comb begin
        if (acc_s) begin
            mem_addr  = addr[win_idx_s*ADDR_W +: ADDR_W];
            mem_wdata = wdata[win_idx_s*DATA_W +: DATA_W];
            mem_we    = we[win_idx_s];
        end else begin
            mem_addr  = {ADDR_W{1'b0}};
            mem_wdata = {DATA_W{1'b0}};
            mem_we    = 1'b0;
        end
    end

    // Arbitration state, burst tracking and read-valid pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= ZERO_IDX;
            owner_r     <= ZERO_IDX;
            burst_cnt_r <= 8'd0;
            rvalid_r    <= {NUM_REQ{1'b0}};
        end else begin
            // Memory read data is registered, so rvalid trails the grant by one cycle.
            rvalid_r <= gnt_s & ~we;
            case (state_r)
                ST_IDLE: begin
                    if (acc_s) begin
                        rr_ptr_r <= wrap_inc(win_idx_s);
                        if (lock[win_idx_s] && BURST_EN) begin
                            state_r     <= ST_LOCKED;
                            owner_r     <= win_idx_s;
                            burst_cnt_r <= 8'd1;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    if (acc_s && lock[owner_r] && (burst_nxt_s != MAX_BURST_W)) begin
                        burst_cnt_r <= burst_nxt_s;
                    end else begin
                        // Release: unlocked access, burst limit hit, or owner went quiet.
                        state_r     <= ST_IDLE;
                        rr_ptr_r    <= wrap_inc(owner_r);
                        burst_cnt_r <= 8'd0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    burst_cnt_r <= 8'd0;
                end
            endcase
        end
    end

    assign gnt    = gnt_s;
    assign rvalid = rvalid_r;
    assign rdata  = mem_rdata;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] grant_cnt_r [NUM_REQ];

    // Per-port saturating counters of accepted accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt_r[i] <= 16'd0;
            end
        end else if (stat_clr) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt_r[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt_s[i] && (grant_cnt_r[i] != 16'hFFFF)) begin
                    grant_cnt_r[i] <= grant_cnt_r[i] + 16'd1;
                end else begin
                    grant_cnt_r[i] <= grant_cnt_r[i];
                end
            end
        end
    end

    // Flatten the counters onto the output bus.
    always_comb begin
        stat_grants = {(NUM_REQ*16){1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_grants[i*16 +: 16] = grant_cnt_r[i];
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed scenarios followed by randomized traffic, checked against a
// behavioural model of the arbitration rules and of memory contents.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int NR = 3;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NR-1:0] req, lock, we;
    logic [NR*16-1:0] addr, wdata;
    logic [NR-1:0] gnt, rvalid;
    logic [15:0]   rdata, mem_addr, mem_wdata, mem_rdata;
    logic          mem_we;
`ifdef MEM_ARB_STATS_EN
    logic          stat_clr = 1'b0;
    logic [NR*16-1:0] stat_grants;
`endif

    mem_arbiter #(.NUM_REQ(NR), .ADDR_W(16), .DATA_W(16), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .we(we),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
        , .stat_clr(stat_clr), .stat_grants(stat_grants)
`endif
    );

    always #5 clk = ~clk;

    // Contents of a never-written location.
    function automatic logic [15:0] init_val(input logic [7:0] a);
        return 16'h5A00 ^ {8'h00, a};
    endfunction

    // Memory environment: registered read, one-cycle latency.
    logic [15:0] mem_arr [256];
    bit   [255:0] mem_wr;
    always @(posedge clk) begin
        if (mem_we) begin
            mem_arr[mem_addr[7:0]] <= mem_wdata;
            mem_wr[mem_addr[7:0]]  <= 1'b1;
        end
        mem_rdata <= mem_wr[mem_addr[7:0]] ? mem_arr[mem_addr[7:0]] : init_val(mem_addr[7:0]);
    end

    // Reference model state.
    int          checks = 0;
    int          failures = 0;
    int          ptr_m, owner_m, cnt_m;
    bit          locked_m;
    bit          pend_v;
    int          pend_port;
    logic [15:0] pend_data;
    logic [15:0] ref_mem [256];
    bit   [255:0] ref_wr;
    int          last_acc;
    logic [NR-1:0] obs_gnt, obs_rvalid;
    logic [15:0] obs_rdata;
    logic        obs_we;
    logic [15:0] obs_addr;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ptr_m = 0; owner_m = 0; cnt_m = 0; locked_m = 1'b0; pend_v = 1'b0; pend_port = 0;
    endtask

    // Which port should be granted this cycle, -1 for none.
    function automatic int predict();
        int p;
        if (rst_n !== 1'b1) return -1;
        if (locked_m) return req[owner_m] ? owner_m : -1;
        for (int i = 0; i < NR; i++) begin
            p = (ptr_m + i) % NR;
            if (req[p]) return p;
        end
        return -1;
    endfunction

    // Apply the effect of the clock edge given the port that was accepted.
    task automatic model_edge(input int k);
        logic [7:0] a;
        pend_v = 1'b0;
        if (k >= 0) begin
            a = addr[k*16 +: 8];
            if (we[k]) begin
                ref_mem[a] = wdata[k*16 +: 16];
                ref_wr[a]  = 1'b1;
            end else begin
                pend_v    = 1'b1;
                pend_port = k;
                pend_data = ref_wr[a] ? ref_mem[a] : init_val(a);
            end
            if (!locked_m) begin
                ptr_m = (k + 1) % NR;
                if (lock[k] && MB > 1) begin
                    locked_m = 1'b1; owner_m = k; cnt_m = 1;
                end
            end else begin
                cnt_m++;
                if (!lock[k] || cnt_m == MB) begin
                    locked_m = 1'b0; cnt_m = 0; ptr_m = (owner_m + 1) % NR;
                end
            end
        end else if (locked_m) begin
            locked_m = 1'b0; cnt_m = 0; ptr_m = (owner_m + 1) % NR;
        end
    endtask

    // One clock: compare outputs mid-cycle, then advance the model at the edge.
    task automatic do_cycle();
        int k;
        logic [NR-1:0] eg, ev;
        @(negedge clk);
        k  = predict();
        eg = (k >= 0) ? NR'(1 << k) : '0;
        ev = pend_v ? NR'(1 << pend_port) : '0;
        chk("gnt", 16'(gnt), 16'(eg));
        chk("mem_we", 16'(mem_we), (k >= 0) ? 16'(we[k]) : 16'h0000);
        chk("mem_addr", mem_addr, (k >= 0) ? addr[k*16 +: 16] : 16'h0000);
        chk("mem_wdata", mem_wdata, (k >= 0) ? wdata[k*16 +: 16] : 16'h0000);
        chk("rvalid", 16'(rvalid), 16'(ev));
        if (pend_v) chk("rdata", rdata, pend_data);
        obs_gnt = gnt; obs_rvalid = rvalid; obs_rdata = rdata; obs_we = mem_we; obs_addr = mem_addr;
        @(posedge clk);
        if (rst_n === 1'b1) model_edge(k);
        else model_reset();
        last_acc = k;
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req = 3'b111;
        do_cycle();
        do_cycle();
        rst_n = 1'b1;
        req = 3'b000; lock = 3'b000; we = 3'b000;
        model_reset();
    endtask

    task automatic set_port(input int p, input logic w, input logic l,
                            input logic [15:0] a, input logic [15:0] d);
        we[p] = w; lock[p] = l; addr[p*16 +: 16] = a; wdata[p*16 +: 16] = d;
    endtask

    logic [NR-1:0] seq_exp [7];

    initial begin
        rst_n = 1'b0; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
        last_acc = -1;
        model_reset();

        // Reset: outputs quiet even with requests pending.
        apply_reset();

        // Single read from port 0.
        set_port(0, 1'b0, 1'b0, 16'h0004, 16'h0000);
        req = 3'b001;
        do_cycle();
        chk("tp1_gnt", 16'(obs_gnt), 16'h0001);
        chk("tp1_addr", obs_addr, 16'h0004);
        req = 3'b000;
        do_cycle();
        chk("tp1_rvalid", 16'(obs_rvalid), 16'h0001);
        chk("tp1_rdata", obs_rdata, init_val(8'h04));

        // Rotation with all ports requesting.
        apply_reset();
        set_port(0, 1'b0, 1'b0, 16'h0001, 16'h0000);
        set_port(1, 1'b0, 1'b0, 16'h0002, 16'h0000);
        set_port(2, 1'b0, 1'b0, 16'h0003, 16'h0000);
        req = 3'b111;
        seq_exp[0] = 3'b001; seq_exp[1] = 3'b010; seq_exp[2] = 3'b100; seq_exp[3] = 3'b001;
        for (int i = 0; i < 4; i++) begin
            do_cycle();
            chk("tp2_rr", 16'(obs_gnt), 16'(seq_exp[i]));
        end
        req = 3'b000;
        do_cycle();

        // Write then read back from a different port.
        set_port(1, 1'b1, 1'b0, 16'h0010, 16'hBEEF);
        req = 3'b010;
        do_cycle();
        chk("tp3_we_wr", 16'(obs_we), 16'h0001);
        set_port(2, 1'b0, 1'b0, 16'h0010, 16'h0000);
        req = 3'b100;
        do_cycle();
        chk("tp3_we_rd", 16'(obs_we), 16'h0000);
        chk("tp3_no_rv", 16'(obs_rvalid), 16'h0000);
        req = 3'b000;
        do_cycle();
        chk("tp3_rvalid", 16'(obs_rvalid), 16'h0004);
        chk("tp3_rdata", obs_rdata, 16'hBEEF);

        // Burst lock by port 0 up to MAX_BURST.
        apply_reset();
        set_port(0, 1'b0, 1'b1, 16'h0020, 16'h0000);
        set_port(1, 1'b0, 1'b0, 16'h0021, 16'h0000);
        set_port(2, 1'b0, 1'b0, 16'h0022, 16'h0000);
        req = 3'b111;
        seq_exp[0] = 3'b001; seq_exp[1] = 3'b001; seq_exp[2] = 3'b001; seq_exp[3] = 3'b001;
        seq_exp[4] = 3'b010; seq_exp[5] = 3'b100; seq_exp[6] = 3'b001;
        for (int i = 0; i < 7; i++) begin
            do_cycle();
            chk("tp4_burst", 16'(obs_gnt), 16'(seq_exp[i]));
        end
        req = 3'b000; lock = 3'b000;
        do_cycle();

        // Locked owner drops its request: one empty cycle, then release.
        apply_reset();
        set_port(2, 1'b0, 1'b1, 16'h0030, 16'h0000);
        set_port(0, 1'b1, 1'b0, 16'h0031, 16'h1234);
        req = 3'b100;
        do_cycle();
        chk("tp5_own1", 16'(obs_gnt), 16'h0004);
        req = 3'b101;
        do_cycle();
        chk("tp5_own2", 16'(obs_gnt), 16'h0004);
        req = 3'b001;
        do_cycle();
        chk("tp5_idle_gnt", 16'(obs_gnt), 16'h0000);
        chk("tp5_idle_we", 16'(obs_we), 16'h0000);
        do_cycle();
        chk("tp5_rel", 16'(obs_gnt), 16'h0001);

        // Reset pulse right after a read is accepted.
        set_port(1, 1'b0, 1'b0, 16'h0040, 16'h0000);
        req = 3'b010;
        do_cycle();
        chk("tp6_acc", 16'(obs_gnt), 16'h0002);
        set_port(0, 1'b0, 1'b0, 16'h0041, 16'h0000);
        set_port(2, 1'b0, 1'b0, 16'h0042, 16'h0000);
        req = 3'b111; lock = 3'b000;
        rst_n = 1'b0;
        #1;
        chk("tp6_rst_gnt", 16'(gnt), 16'h0000);
        chk("tp6_rst_rv", 16'(rvalid), 16'h0000);
        chk("tp6_rst_we", 16'(mem_we), 16'h0000);
        #1;
        rst_n = 1'b1;
        model_reset();
        do_cycle();
        chk("tp6_gnt", 16'(obs_gnt), 16'h0001);
        chk("tp6_rv", 16'(obs_rvalid), 16'h0000);

        // Randomized traffic obeying the requester hold rules.
        req = 3'b000;
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < NR; p++) begin
                if (req[p] && last_acc != p) begin
                    if ($urandom_range(0, 15) == 0) req[p] = 1'b0;
                end else begin
                    req[p] = ($urandom_range(0, 3) != 0);
                    set_port(p, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                             16'($urandom_range(0, 31)), 16'($urandom));
                end
            end
            do_cycle();
        end
        req = 3'b000;
        do_cycle();
        do_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
